// File: rtl/rca_accum_if.sv
// Operand and result handshake bundle for rca_accum.
// slave is the accumulator side, master drives operands and consumes results.
interface rca_accum_if #(
    parameter int IP_WIDTH  = 4,
    parameter int ACC_WIDTH = 8
);
    logic                 in_valid;
    logic                 in_ready;
    logic [IP_WIDTH-1:0]  in_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [ACC_WIDTH-1:0] out_sum;
    logic                 out_ovf;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_sum, out_ovf
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_sum, out_ovf
    );
endinterface

// File: rtl/rca_accum.sv
// Batch accumulator over a ripple-carry adder with valid/ready result output.
// Define SATURATE_EN to clamp the accumulator at all-ones on carry out.
module rca #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         c_in,
    output logic [W-1:0] sum,
    output logic         c_out
);
    logic [W:0] c;

    assign c[0] = c_in;

    for (genvar i = 0; i < W; i++) begin : g_fa
        assign sum[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign c_out = c[W];
endmodule

module rca_accum #(
    parameter int IP_WIDTH  = 4,
    parameter int ACC_WIDTH = 8,
    parameter int COUNT     = 4
) (
    input  logic          clk,
    input  logic          rst,
    rca_accum_if.slave    bus
);
    localparam int CW = $clog2(COUNT) + 1;

    typedef enum logic {
        ACC  = 1'b0,
        DONE = 1'b1
    } state_t;

    state_t               state;
    state_t               state_nx;
    logic [ACC_WIDTH-1:0] acc;
    logic [CW-1:0]        cnt;
    logic                 ovf;
    logic [ACC_WIDTH-1:0] sum;
    logic                 c_out;
    logic [ACC_WIDTH-1:0] acc_nx;
    logic                 ovf_nx;
    logic                 fire;
    logic                 last;

    rca #(.W(ACC_WIDTH)) u_rca (
        .a     (acc),
        .b     (ACC_WIDTH'(bus.in_data)),
        .c_in  (1'b0),
        .sum   (sum),
        .c_out (c_out)
    );

`ifdef SATURATE_EN
    assign acc_nx = c_out ? {ACC_WIDTH{1'b1}} : sum;
`else
    assign acc_nx = sum;
`endif

    assign ovf_nx = ovf | c_out;
    assign fire   = bus.in_valid && bus.in_ready;
    assign last   = (cnt == CW'(COUNT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ACC;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            ACC:  if (fire && last) state_nx = DONE;
            DONE: if (bus.out_ready) state_nx = ACC;
            default: state_nx = ACC;
        endcase
    end

    always_comb begin
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        unique case (state)
            ACC:  bus.in_ready  = 1'b1;
            DONE: bus.out_valid = 1'b1;
            default: bus.in_ready = 1'b0;
        endcase
    end

    // The completing operand's sum goes straight to the result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc         <= '0;
            cnt         <= '0;
            ovf         <= 1'b0;
            bus.out_sum <= '0;
            bus.out_ovf <= 1'b0;
        end else if (fire) begin
            if (last) begin
                bus.out_sum <= acc_nx;
                bus.out_ovf <= ovf_nx;
                acc         <= '0;
                cnt         <= '0;
                ovf         <= 1'b0;
            end else begin
                acc <= acc_nx;
                cnt <= cnt + CW'(1);
                ovf <= ovf_nx;
            end
        end
    end
endmodule

// File: tb/tb_rca_accum.sv
// Self-checking bench for rca_accum (IP_WIDTH=4, ACC_WIDTH=5, COUNT=4).
// Define SATURATE_EN for both RTL and bench to exercise saturation.
module tb_rca_accum;
    localparam int IW = 4;
    localparam int AW = 5;
    localparam int N  = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    rca_accum_if #(.IP_WIDTH(IW), .ACC_WIDTH(AW)) bus ();

    rca_accum #(
        .IP_WIDTH  (IW),
        .ACC_WIDTH (AW),
        .COUNT     (N)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        int d[4];
        int sum;
        int ovf;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Plain-arithmetic reference: running integer sum, clamped or wrapped.
    task automatic model(input int d[4], output int s, output int o);
        s = 0;
        o = 0;
        for (int i = 0; i < N; i++) begin
            s = s + d[i];
            if (s >= (1 << AW)) begin
                o = 1;
`ifdef SATURATE_EN
                s = (1 << AW) - 1;
`else
                s = s - (1 << AW);
`endif
            end
        end
    endtask

    // Called at a negedge; returns at the negedge after the accept edge.
    task automatic send(input int d);
        int n;
        n = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = IW'(d);
        while (!bus.in_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) chk("send_timeout", 0, 1);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic get_result(input string name, input int s, input int o);
        int n;
        n = 0;
        while (!bus.out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_valid"}, int'(bus.out_valid), 1);
        chk({name, "_sum"}, int'(bus.out_sum), s);
        chk({name, "_ovf"}, int'(bus.out_ovf), o);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk({name, "_drop"}, int'(bus.out_valid), 0);
    endtask

    vec_t tbl[4];
    int   s_exp;
    int   o_exp;
    int   held;
    int   rd[4];

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;

        tbl[0] = '{d: '{1, 2, 3, 4}, sum: 10, ovf: 0};
`ifdef SATURATE_EN
        tbl[1] = '{d: '{15, 15, 15, 15}, sum: 31, ovf: 1};
        tbl[3] = '{d: '{8, 8, 8, 8}, sum: 31, ovf: 1};
`else
        tbl[1] = '{d: '{15, 15, 15, 15}, sum: 28, ovf: 1};
        tbl[3] = '{d: '{8, 8, 8, 8}, sum: 0, ovf: 1};
`endif
        tbl[2] = '{d: '{0, 0, 0, 1}, sum: 1, ovf: 0};

        repeat (2) @(negedge clk);
        chk("rst_in_ready", int'(bus.in_ready), 1);
        chk("rst_out_valid", int'(bus.out_valid), 0);
        chk("rst_out_sum", int'(bus.out_sum), 0);
        chk("rst_out_ovf", int'(bus.out_ovf), 0);
        rst = 1'b0;

        // Back-to-back table batches with latency and DONE-state checks.
        for (int t = 0; t < 4; t++) begin
            for (int i = 0; i < N; i++) begin
                if (i == N - 1)
                    chk($sformatf("t%0d_pre_valid", t), int'(bus.out_valid), 0);
                send(tbl[t].d[i]);
            end
            chk($sformatf("t%0d_lat", t), int'(bus.out_valid), 1);
            chk($sformatf("t%0d_in_ready", t), int'(bus.in_ready), 0);
            get_result($sformatf("t%0d", t), tbl[t].sum, tbl[t].ovf);
        end

        // Result held under back-pressure; operand must wait upstream.
        for (int i = 0; i < N; i++) send(3);
        bus.in_valid = 1'b1;
        bus.in_data  = 4'd7;
        held = int'(bus.out_sum);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_in_ready", int'(bus.in_ready), 0);
            chk("bp_sum_stable", int'(bus.out_sum), held);
        end
        chk("bp_sum", held, 12);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        send(7);
        send(1);
        send(1);
        send(1);
        get_result("bp_next", 10, 0);

        // Input gaps, with a stray out_ready while no result is pending.
        send(2);
        bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("gap_out_valid", int'(bus.out_valid), 0);
        chk("gap_in_ready", int'(bus.in_ready), 1);
        bus.out_ready = 1'b0;
        send(2);
        send(2);
        send(2);
        get_result("gap", 8, 0);

        // Reset mid-batch drops the partial sum and count.
        send(5);
        send(5);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_out_valid", int'(bus.out_valid), 0);
        for (int i = 0; i < N; i++) send(1);
        get_result("mid_rst", 4, 0);

        // Random batches against the reference model.
        for (int b = 0; b < 40; b++) begin
            for (int i = 0; i < N; i++) rd[i] = int'($urandom_range(0, 15));
            model(rd, s_exp, o_exp);
            for (int i = 0; i < N; i++) begin
                repeat ($urandom_range(0, 2)) @(negedge clk);
                send(rd[i]);
            end
            repeat ($urandom_range(0, 3)) @(negedge clk);
            get_result($sformatf("rnd%0d", b), s_exp, o_exp);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end
endmodule
